// File: rtl/mips_pkg.sv
// Shared MIPS definitions: well-known instruction words, the fetch-stage
// per-edge action encoding and a constant clog2 used for address widths.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR           = 32'h0000_0000;
    localparam logic [31:0] HALT_OPCODE_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_BRANCH,
        ACT_FETCH
    } fetch_act_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = (value > 1) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prog_mem_ram.sv
// Program memory: one synchronous write port, one asynchronous read port.
// Contents start at zero and are loaded through the write port.
module prog_mem_ram
    import mips_pkg::*;
#(
    parameter int unsigned NB_DATA   = 32,
    parameter int unsigned DEPTH     = 2048,
    parameter              INIT_FILE = ""
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [clog2(DEPTH)-1:0]   i_waddr,
    input  logic [NB_DATA-1:0]        i_wdata,
    input  logic [clog2(DEPTH)-1:0]   i_raddr,
    output logic [NB_DATA-1:0]        o_rdata
);

    logic [NB_DATA-1:0] mem_q [DEPTH];

    initial mem_q = '{default: '0};

    // NOTE: no reset on the array -- a reset must leave the loaded program intact.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/seg_instruction_fetch_pipe.sv
// MIPS instruction-fetch stage: PC register, debug-loadable program memory and
// the IF/ID register, with stall, branch flush, HALT freeze and debug enable.
module seg_instruction_fetch_pipe
    import mips_pkg::*;
#(
    parameter int unsigned           NB_INSTRUC        = 32,
    parameter int unsigned           NB_ADDR           = 32,
    parameter int unsigned           RAM_DEPTH_PROGRAM = 2048,
    parameter int unsigned           PC_STEP           = 1,
    parameter logic [NB_INSTRUC-1:0] HALT_OPCODE       = NB_INSTRUC'(HALT_OPCODE_DEFAULT),
    parameter                        INIT_FILE_PROGRAM = ""
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_enable,
    input  logic                                  i_stall,
    input  logic                                  i_PCSrc,
    input  logic [NB_ADDR-1:0]                    i_PC_branch,
    input  logic                                  i_prog_we,
    input  logic [clog2(RAM_DEPTH_PROGRAM)-1:0]   i_prog_addr,
    input  logic [NB_INSTRUC-1:0]                 i_prog_data,
    output logic [NB_INSTRUC-1:0]                 o_instruction,
    output logic [NB_ADDR-1:0]                    o_PC,
    output logic                                  o_valid,
    output logic                                  o_halt,
    output logic [NB_ADDR-1:0]                    o_pc_current
);

    localparam int unsigned ADDR_W  = clog2(RAM_DEPTH_PROGRAM);
    localparam int unsigned STEP_SH = clog2(PC_STEP);

    logic [NB_ADDR-1:0]    pc_q, pc_d, pc_plus;
    logic [NB_INSTRUC-1:0] instr_q, instr_d;
    logic [NB_ADDR-1:0]    opc_q, opc_d;
    logic                  valid_q, valid_d;
    logic                  halt_q, halt_d;
    logic [ADDR_W-1:0]     rd_addr;
    logic [NB_INSTRUC-1:0] fetch_word;
    fetch_act_e            act;

    // Word index is PC/PC_STEP with the upper bits dropped, so fetches wrap.
    assign rd_addr = pc_q[STEP_SH +: ADDR_W];
    assign pc_plus = pc_q + NB_ADDR'(PC_STEP);

    prog_mem_ram #(
        .NB_DATA   (NB_INSTRUC),
        .DEPTH     (RAM_DEPTH_PROGRAM),
        .INIT_FILE (INIT_FILE_PROGRAM)
    ) u_prog_mem (
        .i_clk   (i_clk),
        .i_we    (i_prog_we),
        .i_waddr (i_prog_addr),
        .i_wdata (i_prog_data),
        .i_raddr (rd_addr),
        .o_rdata (fetch_word)
    );

    always_comb begin
        if (i_prog_we || !i_enable) begin
            act = ACT_HOLD;
        end else if (i_PCSrc) begin
            act = ACT_BRANCH;
        end else if (i_stall || halt_q) begin
            act = ACT_HOLD;
        end else begin
            act = ACT_FETCH;
        end
    end

    always_comb begin
        // NOTE: every _d takes its hold value first so no path leaves it unassigned (no latch).
        pc_d    = pc_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        case (act)
            ACT_BRANCH: begin
                pc_d    = i_PC_branch;
                instr_d = NB_INSTRUC'(NOP_INSTR);
                opc_d   = '0;
                valid_d = 1'b0;
                halt_d  = 1'b0;
            end
            ACT_FETCH: begin
                pc_d    = pc_plus;
                instr_d = fetch_word;
                opc_d   = pc_plus;
                valid_d = 1'b1;
                halt_d  = (fetch_word == HALT_OPCODE);
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all of them update together.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pc_q    <= '0;
            instr_q <= NB_INSTRUC'(NOP_INSTR);
            opc_q   <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
        end
    end

    assign o_instruction = instr_q;
    assign o_PC          = opc_q;
    assign o_valid       = valid_q;
    assign o_halt        = halt_q;
    assign o_pc_current  = pc_q;

endmodule

// File: tb/tb_seg_instruction_fetch_pipe.sv
// Bench for the fetch stage: a word-addressed 2048-deep instance and a
// byte-addressed 16-deep instance, each tracked by a behavioural model.
module tb_seg_instruction_fetch_pipe;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        stall;
        logic        pcsrc;
        logic        we;
        logic [31:0] br;
        logic [10:0] addr;
        logic [31:0] data;
    } in_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] opc;
        logic        valid;
        logic        halt;
    } st_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t a_in = '0;
    in_t b_in = '0;

    logic [31:0] a_instr, a_opc, a_pc;
    logic        a_valid, a_halt;
    logic [31:0] b_instr, b_opc, b_pc;
    logic        b_valid, b_halt;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    seg_instruction_fetch_pipe #(
        .NB_INSTRUC(32), .NB_ADDR(32), .RAM_DEPTH_PROGRAM(2048), .PC_STEP(1)
    ) dut_a (
        .i_clk(clk), .i_rst(a_in.rst), .i_enable(a_in.en), .i_stall(a_in.stall),
        .i_PCSrc(a_in.pcsrc), .i_PC_branch(a_in.br), .i_prog_we(a_in.we),
        .i_prog_addr(a_in.addr), .i_prog_data(a_in.data),
        .o_instruction(a_instr), .o_PC(a_opc), .o_valid(a_valid),
        .o_halt(a_halt), .o_pc_current(a_pc)
    );

    seg_instruction_fetch_pipe #(
        .NB_INSTRUC(32), .NB_ADDR(32), .RAM_DEPTH_PROGRAM(16), .PC_STEP(4)
    ) dut_b (
        .i_clk(clk), .i_rst(b_in.rst), .i_enable(b_in.en), .i_stall(b_in.stall),
        .i_PCSrc(b_in.pcsrc), .i_PC_branch(b_in.br), .i_prog_we(b_in.we),
        .i_prog_addr(b_in.addr[3:0]), .i_prog_data(b_in.data),
        .o_instruction(b_instr), .o_PC(b_opc), .o_valid(b_valid),
        .o_halt(b_halt), .o_pc_current(b_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference behaviour: one clock edge of the stage, straight from the priority list.
    function automatic st_t model_next(st_t s, in_t in, logic [31:0] fw, int unsigned step);
        st_t n;
        n = s;
        if (!in.rst) begin
            n = '0;
        end else if (in.we || !in.en) begin
            n = s;
        end else if (in.pcsrc) begin
            n.pc    = in.br;
            n.instr = 32'h0;
            n.opc   = 32'h0;
            n.valid = 1'b0;
            n.halt  = 1'b0;
        end else if (in.stall || s.halt) begin
            n = s;
        end else begin
            n.pc    = 32'(s.pc + step);
            n.instr = fw;
            n.opc   = 32'(s.pc + step);
            n.valid = 1'b1;
            n.halt  = (fw == HALT);
        end
        return n;
    endfunction

    function automatic int a_idx(logic [31:0] pc);
        return int'(pc % 32'd2048);
    endfunction

    function automatic int b_idx(logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd16);
    endfunction

    st_t         ma = '0;
    st_t         mb = '0;
    logic [31:0] ma_mem [2048];
    logic [31:0] mb_mem [16];

    always @(posedge clk) begin
        ma <= model_next(ma, a_in, ma_mem[a_idx(ma.pc)], 1);
        mb <= model_next(mb, b_in, mb_mem[b_idx(mb.pc)], 4);
        if (a_in.we) ma_mem[a_in.addr] <= a_in.data;
        if (b_in.we) mb_mem[b_in.addr[3:0]] <= b_in.data;
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("a_instruction", a_instr, ma.instr);
            check("a_PC", a_opc, ma.opc);
            check("a_valid", 32'(a_valid), 32'(ma.valid));
            check("a_halt", 32'(a_halt), 32'(ma.halt));
            check("a_pc_current", a_pc, ma.pc);
            check("b_instruction", b_instr, mb.instr);
            check("b_PC", b_opc, mb.opc);
            check("b_valid", 32'(b_valid), 32'(mb.valid));
            check("b_halt", 32'(b_halt), 32'(mb.halt));
            check("b_pc_current", b_pc, mb.pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic in_t rand_in(int unsigned br_max);
        in_t r;
        r.rst   = ($urandom_range(0, 99) != 0);
        r.en    = ($urandom_range(0, 7) != 0);
        r.stall = ($urandom_range(0, 3) == 0);
        r.pcsrc = ($urandom_range(0, 5) == 0);
        r.we    = ($urandom_range(0, 15) == 0);
        r.br    = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, br_max);
        r.addr  = 11'($urandom);
        r.data  = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
        return r;
    endfunction

    initial begin
        logic [31:0] w;
        // Load both memories while both stages sit in reset.
        a_in.rst = 1'b0;
        b_in.rst = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            case (i)
                0:       w = 32'h11;
                1:       w = 32'h22;
                2:       w = 32'h33;
                3:       w = 32'h44;
                4:       w = HALT;
                8:       w = 32'h88;
                2047:    w = 32'h7FF0_07FF;
                default: w = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
            endcase
            a_in.we   = 1'b1;
            a_in.addr = 11'(i);
            a_in.data = w;
            b_in.we   = (i < 16);
            b_in.addr = 11'(i);
            b_in.data = 32'hB0 + 32'(i);
            tick();
        end
        a_in.we = 1'b0;
        b_in.we = 1'b0;
        tick();
        cmp_on = 1'b1;
        check("reset_instruction", a_instr, 32'h0);
        check("reset_PC", a_opc, 32'h0);
        check("reset_valid", 32'(a_valid), 32'h0);
        check("reset_halt", 32'(a_halt), 32'h0);
        check("reset_pc_current", a_pc, 32'h0);

        // Sequential fetch, then a two-cycle stall.
        a_in.rst = 1'b1;
        a_in.en  = 1'b1;
        tick();
        check("fetch0_instr", a_instr, 32'h11);
        check("fetch0_PC", a_opc, 32'h1);
        check("fetch0_valid", 32'(a_valid), 32'h1);
        tick();
        check("fetch1_instr", a_instr, 32'h22);
        check("fetch1_PC", a_opc, 32'h2);
        a_in.stall = 1'b1;
        tick();
        tick();
        check("stall_instr", a_instr, 32'h22);
        check("stall_pc_current", a_pc, 32'h2);
        a_in.stall = 1'b0;
        tick();
        check("resume_instr", a_instr, 32'h33);
        check("resume_PC", a_opc, 32'h3);

        // Branch wins over a simultaneous stall.
        a_in.pcsrc = 1'b1;
        a_in.br    = 32'd8;
        a_in.stall = 1'b1;
        tick();
        check("flush_valid", 32'(a_valid), 32'h0);
        check("flush_instr", a_instr, 32'h0);
        check("flush_pc_current", a_pc, 32'd8);
        a_in.pcsrc = 1'b0;
        a_in.stall = 1'b0;
        tick();
        check("target_instr", a_instr, 32'h88);
        check("target_PC", a_opc, 32'd9);

        // Run into the HALT at word 4, sit frozen, then branch out of it.
        a_in.pcsrc = 1'b1;
        a_in.br    = 32'd2;
        tick();
        a_in.pcsrc = 1'b0;
        tick();
        tick();
        tick();
        check("halt_flag", 32'(a_halt), 32'h1);
        check("halt_pc_current", a_pc, 32'd5);
        check("halt_instr", a_instr, HALT);
        repeat (10) tick();
        check("halt_hold_flag", 32'(a_halt), 32'h1);
        check("halt_hold_pc", a_pc, 32'd5);
        a_in.pcsrc = 1'b1;
        a_in.br    = 32'd0;
        tick();
        check("unhalt_flag", 32'(a_halt), 32'h0);
        check("unhalt_pc_current", a_pc, 32'd0);
        a_in.pcsrc = 1'b0;
        tick();
        check("restart_instr", a_instr, 32'h11);

        // Debug load while running holds the PC; reset then fetches the new words.
        for (int i = 0; i < 4; i++) begin
            a_in.we   = 1'b1;
            a_in.addr = 11'(i);
            a_in.data = 32'hA0 + 32'(i);
            tick();
            check("load_pc_hold", a_pc, 32'd1);
        end
        a_in.we  = 1'b0;
        a_in.rst = 1'b0;
        tick();
        a_in.rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("reload_instr", a_instr, 32'hA0 + 32'(i));
            check("reload_PC", a_opc, 32'(i + 1));
        end

        // PC wraps from all-ones to zero; the index wraps onto the last word.
        a_in.pcsrc = 1'b1;
        a_in.br    = 32'hFFFF_FFFF;
        tick();
        check("wrap_pc_current", a_pc, 32'hFFFF_FFFF);
        a_in.pcsrc = 1'b0;
        tick();
        check("wrap_instr", a_instr, 32'h7FF0_07FF);
        check("wrap_PC", a_opc, 32'h0);
        check("wrap_pc_next", a_pc, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            a_in = rand_in(40);
            tick();
        end
        a_in    = '0;
        a_in.en = 1'b0;

        // Byte-addressed instance: 60 maps to word 15, 64 wraps to word 0.
        b_in.rst = 1'b1;
        b_in.en  = 1'b1;
        tick();
        check("b_fetch0_instr", b_instr, 32'hB0);
        check("b_fetch0_PC", b_opc, 32'd4);
        b_in.pcsrc = 1'b1;
        b_in.br    = 32'd60;
        tick();
        check("b_flush_pc_current", b_pc, 32'd60);
        b_in.pcsrc = 1'b0;
        tick();
        check("b_word15_instr", b_instr, 32'hBF);
        check("b_word15_PC", b_opc, 32'd64);
        tick();
        check("b_wrap_instr", b_instr, 32'hB0);
        check("b_wrap_PC", b_opc, 32'd68);
        b_in.rst = 1'b0;
        tick();
        check("b_rst_instr", b_instr, 32'h0);
        check("b_rst_PC", b_opc, 32'h0);
        check("b_rst_valid", 32'(b_valid), 32'h0);
        check("b_rst_halt", 32'(b_halt), 32'h0);
        check("b_rst_pc_current", b_pc, 32'h0);
        b_in.rst = 1'b1;

        for (int c = 0; c < 1000; c++) begin
            b_in = rand_in(80);
            tick();
        end

        @(negedge clk);
        #1;
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
